// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the memory port.
// The master modport is the arbiter's view; slave is the pipeline plus memory side.
interface mem_bus_arbiter_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  logic        mreq_valid;
  logic        mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ready;
  logic [63:0] mresp_data;

  modport master (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    input  mresp_ready, mresp_data
  );

  modport slave (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    output mresp_ready, mresp_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between ibus and dbus; one outstanding request at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants instead of dbus priority + starve limit.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  mem_bus_arbiter_if.master  bus_io
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic        grant_i, grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dbus_q, last_dbus_d;
`else
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  // Arbitration is only evaluated while idle; busy-time requests are ignored.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (bus_io.ireq_valid && bus_io.dreq_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_i = last_dbus_q;
`else
        grant_i = (starve_cnt_q >= 4'(STARVE_LIMIT));
`endif
        grant_d = ~grant_i;
      end else begin
        grant_i = bus_io.ireq_valid;
        grant_d = bus_io.dreq_valid;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_dbus_d = last_dbus_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d  = StIBusy;
          addr_d   = bus_io.ireq_addr;
          size_d   = 3'd2;
          strobe_d = 8'h00;
          wdata_d  = 64'h0;
        end else if (grant_d) begin
          state_d  = StDBusy;
          addr_d   = bus_io.dreq_addr;
          size_d   = bus_io.dreq_size;
          strobe_d = bus_io.dreq_strobe;
          wdata_d  = bus_io.dreq_data;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (grant_i) last_dbus_d = 1'b0;
        else if (grant_d) last_dbus_d = 1'b1;
`else
        if (grant_i || !bus_io.ireq_valid) starve_cnt_d = 4'd0;
        else if (grant_d) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
      end
      StIBusy, StDBusy: begin
        if (bus_io.mresp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= 64'h0;
      size_q   <= 3'd0;
      strobe_q <= 8'h00;
      wdata_q  <= 64'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dbus_q <= 1'b0;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dbus_q <= last_dbus_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign bus_io.iresp_addr_ok = grant_i;
  assign bus_io.dresp_addr_ok = grant_d;
  assign bus_io.iresp_data_ok = (state_q == StIBusy) && bus_io.mresp_ready;
  assign bus_io.dresp_data_ok = (state_q == StDBusy) && bus_io.mresp_ready;

  // Responses read as zero outside their data_ok pulse.
  assign bus_io.iresp_data = !bus_io.iresp_data_ok ? 32'h0 :
                             addr_q[2] ? bus_io.mresp_data[63:32] : bus_io.mresp_data[31:0];
  assign bus_io.dresp_data = bus_io.dresp_data_ok ? bus_io.mresp_data : 64'h0;

  assign bus_io.mreq_valid    = (state_q != StIdle);
  assign bus_io.mreq_is_write = (strobe_q != 8'h00);
  assign bus_io.mreq_addr     = addr_q;
  assign bus_io.mreq_size     = size_q;
  assign bus_io.mreq_strobe   = strobe_q;
  assign bus_io.mreq_data     = wdata_q;

endmodule
